// File: rtl/des_decrypt_core_if.sv
// Ready/valid bundle between the receive buffer, the DES decrypt core and the plaintext consumer.
interface des_decrypt_core_if;
  logic        in_valid;
  logic        in_ready;
  logic [63:0] ciphertext;
  logic [63:0] key;
  logic        out_valid;
  logic        out_ready;
  logic [63:0] plaintext;
  logic        busy;

  modport master (
    output in_valid, ciphertext, key, out_ready,
    input  in_ready, out_valid, plaintext, busy
  );

  modport slave (
    input  in_valid, ciphertext, key, out_ready,
    output in_ready, out_valid, plaintext, busy
  );
endinterface

// File: rtl/des_decrypt_core.sv
// Iterative DES decryption: one Feistel round per clock, subkeys generated by
// right-rotating C/D from the PC-1 state so K16 is applied first.
module des_decrypt_core (
  input  logic              clk_i,
  input  logic              rst_i,
  des_decrypt_core_if.slave bus_io
);
  // state | meaning
  // IDLE  | waiting for a ciphertext/key pair, in_ready high
  // ROUND | one round per clock, subkeys K16 down to K1, busy high
  // DONE  | plaintext held with out_valid until the consumer takes it
  typedef enum logic [1:0] {IDLE, ROUND, DONE} state_e;

  localparam int IP_T [64] = '{58,50,42,34,26,18,10,2, 60,52,44,36,28,20,12,4,
                               62,54,46,38,30,22,14,6, 64,56,48,40,32,24,16,8,
                               57,49,41,33,25,17,9,1,  59,51,43,35,27,19,11,3,
                               61,53,45,37,29,21,13,5, 63,55,47,39,31,23,15,7};
  localparam int FP_T [64] = '{40,8,48,16,56,24,64,32, 39,7,47,15,55,23,63,31,
                               38,6,46,14,54,22,62,30, 37,5,45,13,53,21,61,29,
                               36,4,44,12,52,20,60,28, 35,3,43,11,51,19,59,27,
                               34,2,42,10,50,18,58,26, 33,1,41,9,49,17,57,25};
  localparam int E_T [48]  = '{32,1,2,3,4,5, 4,5,6,7,8,9, 8,9,10,11,12,13, 12,13,14,15,16,17,
                               16,17,18,19,20,21, 20,21,22,23,24,25, 24,25,26,27,28,29, 28,29,30,31,32,1};
  localparam int P_T [32]  = '{16,7,20,21,29,12,28,17, 1,15,23,26,5,18,31,10,
                               2,8,24,14,32,27,3,9, 19,13,30,6,22,11,4,25};
  localparam int PC1_T [56] = '{57,49,41,33,25,17,9, 1,58,50,42,34,26,18, 10,2,59,51,43,35,27,
                                19,11,3,60,52,44,36, 63,55,47,39,31,23,15, 7,62,54,46,38,30,22,
                                14,6,61,53,45,37,29, 21,13,5,28,20,12,4};
  localparam int PC2_T [48] = '{14,17,11,24,1,5, 3,28,15,6,21,10, 23,19,12,4,26,8, 16,7,27,20,13,2,
                                41,52,31,37,47,55, 30,40,51,45,33,48, 44,49,39,56,34,53, 46,42,50,36,29,32};
  // S-box entry index is {row, col} = {b1, b6, b2..b5} of the 6-bit group.
  localparam logic [3:0] SBOX [8][64] = '{
    '{14,4,13,1,2,15,11,8,3,10,6,12,5,9,0,7, 0,15,7,4,14,2,13,1,10,6,12,11,9,5,3,8,
      4,1,14,8,13,6,2,11,15,12,9,7,3,10,5,0, 15,12,8,2,4,9,1,7,5,11,3,14,10,0,6,13},
    '{15,1,8,14,6,11,3,4,9,7,2,13,12,0,5,10, 3,13,4,7,15,2,8,14,12,0,1,10,6,9,11,5,
      0,14,7,11,10,4,13,1,5,8,12,6,9,3,2,15, 13,8,10,1,3,15,4,2,11,6,7,12,0,5,14,9},
    '{10,0,9,14,6,3,15,5,1,13,12,7,11,4,2,8, 13,7,0,9,3,4,6,10,2,8,5,14,12,11,15,1,
      13,6,4,9,8,15,3,0,11,1,2,12,5,10,14,7, 1,10,13,0,6,9,8,7,4,15,14,3,11,5,2,12},
    '{7,13,14,3,0,6,9,10,1,2,8,5,11,12,4,15, 13,8,11,5,6,15,0,3,4,7,2,12,1,10,14,9,
      10,6,9,0,12,11,7,13,15,1,3,14,5,2,8,4, 3,15,0,6,10,1,13,8,9,4,5,11,12,7,2,14},
    '{2,12,4,1,7,10,11,6,8,5,3,15,13,0,14,9, 14,11,2,12,4,7,13,1,5,0,15,10,3,9,8,6,
      4,2,1,11,10,13,7,8,15,9,12,5,6,3,0,14, 11,8,12,7,1,14,2,13,6,15,0,9,10,4,5,3},
    '{12,1,10,15,9,2,6,8,0,13,3,4,14,7,5,11, 10,15,4,2,7,12,9,5,6,1,13,14,0,11,3,8,
      9,14,15,5,2,8,12,3,7,0,4,10,1,13,11,6, 4,3,2,12,9,5,15,10,11,14,1,7,6,0,8,13},
    '{4,11,2,14,15,0,8,13,3,12,9,7,5,10,6,1, 13,0,11,7,4,9,1,10,14,3,5,12,2,15,8,6,
      1,4,11,13,12,3,7,14,10,15,6,8,0,5,9,2, 6,11,13,8,1,4,10,7,9,5,0,15,14,2,3,12},
    '{13,2,8,4,6,15,11,1,10,9,3,14,5,0,12,7, 1,15,13,8,10,3,7,4,12,5,6,11,0,14,9,2,
      7,11,4,1,9,12,14,2,0,6,10,13,15,3,5,8, 2,1,14,7,4,10,8,13,15,12,9,0,3,5,6,11}
  };

  function automatic logic [63:0] ip_perm(input logic [63:0] x);
    logic [63:0] y;
    for (int i = 0; i < 64; i++) y[6'(63 - i)] = x[6'(64 - IP_T[6'(i)])];
    return y;
  endfunction

  function automatic logic [63:0] fp_perm(input logic [63:0] x);
    logic [63:0] y;
    for (int i = 0; i < 64; i++) y[6'(63 - i)] = x[6'(64 - FP_T[6'(i)])];
    return y;
  endfunction

  function automatic logic [55:0] pc1_perm(input logic [63:0] x);
    logic [55:0] y;
    for (int i = 0; i < 56; i++) y[6'(55 - i)] = x[6'(64 - PC1_T[6'(i)])];
    return y;
  endfunction

  function automatic logic [47:0] pc2_perm(input logic [55:0] x);
    logic [47:0] y;
    for (int i = 0; i < 48; i++) y[6'(47 - i)] = x[6'(56 - PC2_T[6'(i)])];
    return y;
  endfunction

  function automatic logic [31:0] feistel(input logic [31:0] r, input logic [47:0] k);
    logic [47:0] x;
    logic [31:0] s;
    logic [31:0] y;
    logic [5:0]  b;
    s = '0;
    for (int i = 0; i < 48; i++) x[6'(47 - i)] = r[5'(32 - E_T[6'(i)])];
    x = x ^ k;
    for (int j = 0; j < 8; j++) begin
      b = 6'(x >> (42 - 6 * j));
      s = {s[27:0], SBOX[3'(j)][{b[5], b[0], b[4:1]}]};
    end
    for (int i = 0; i < 32; i++) y[5'(31 - i)] = s[5'(32 - P_T[5'(i)])];
    return y;
  endfunction

  state_e      state_q;
  logic [3:0]  cnt_q;
  logic [31:0] l_q, r_q;
  logic [27:0] c_q, d_q;
  logic [63:0] pt_q;
  logic        out_valid_q, busy_q, in_ready_q;

  logic [47:0] subkey;
  logic [31:0] l_d, r_d;
  logic [27:0] c_d, d_d;

  // C/D advance toward the next (lower-numbered) subkey; single-step rotations precede K15, K8 and K1.
  always_comb begin
    subkey = pc2_perm({c_q, d_q});
    l_d    = r_q;
    r_d    = l_q ^ feistel(r_q, subkey);
    if (cnt_q == 4'd0 || cnt_q == 4'd7 || cnt_q == 4'd14) begin
      c_d = {c_q[0], c_q[27:1]};
      d_d = {d_q[0], d_q[27:1]};
    end else begin
      c_d = {c_q[1:0], c_q[27:2]};
      d_d = {d_q[1:0], d_q[27:2]};
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q     <= IDLE;
      cnt_q       <= 4'd0;
      l_q         <= '0;
      r_q         <= '0;
      c_q         <= '0;
      d_q         <= '0;
      pt_q        <= '0;
      out_valid_q <= 1'b0;
      busy_q      <= 1'b0;
      in_ready_q  <= 1'b1;
    end else begin
      case (state_q)
        IDLE: begin
          if (bus_io.in_valid) begin
            {l_q, r_q} <= ip_perm(bus_io.ciphertext);
            {c_q, d_q} <= pc1_perm(bus_io.key);
            cnt_q      <= 4'd0;
            busy_q     <= 1'b1;
            in_ready_q <= 1'b0;
            state_q    <= ROUND;
          end
        end
        ROUND: begin
          l_q   <= l_d;
          r_q   <= r_d;
          c_q   <= c_d;
          d_q   <= d_d;
          cnt_q <= cnt_q + 4'd1;
          if (cnt_q == 4'd15) begin
            pt_q        <= fp_perm({r_d, l_d});
            busy_q      <= 1'b0;
            out_valid_q <= 1'b1;
            state_q     <= DONE;
          end
        end
        DONE: begin
          if (bus_io.out_ready) begin
            out_valid_q <= 1'b0;
            in_ready_q  <= 1'b1;
            state_q     <= IDLE;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign bus_io.in_ready  = in_ready_q;
  assign bus_io.out_valid = out_valid_q;
  assign bus_io.plaintext = pt_q;
  assign bus_io.busy      = busy_q;
endmodule

// File: tb/tb_des_decrypt_core.sv
// Bench for des_decrypt_core: textbook DES model (encryption key schedule, reversed)
// plus a transaction-level timing model checked against the DUT on every cycle.
module tb_des_decrypt_core;
  logic clk = 1'b0;
  logic rst = 1'b1;
  des_decrypt_core_if bus ();

  des_decrypt_core dut (.clk_i(clk), .rst_i(rst), .bus_io(bus));

  always #5 clk = ~clk;

  int IP_B[$]  = '{58,50,42,34,26,18,10,2,60,52,44,36,28,20,12,4,62,54,46,38,30,22,14,6,
                   64,56,48,40,32,24,16,8,57,49,41,33,25,17,9,1,59,51,43,35,27,19,11,3,
                   61,53,45,37,29,21,13,5,63,55,47,39,31,23,15,7};
  int FP_B[$]  = '{40,8,48,16,56,24,64,32,39,7,47,15,55,23,63,31,38,6,46,14,54,22,62,30,
                   37,5,45,13,53,21,61,29,36,4,44,12,52,20,60,28,35,3,43,11,51,19,59,27,
                   34,2,42,10,50,18,58,26,33,1,41,9,49,17,57,25};
  int E_B[$]   = '{32,1,2,3,4,5,4,5,6,7,8,9,8,9,10,11,12,13,12,13,14,15,16,17,
                   16,17,18,19,20,21,20,21,22,23,24,25,24,25,26,27,28,29,28,29,30,31,32,1};
  int P_B[$]   = '{16,7,20,21,29,12,28,17,1,15,23,26,5,18,31,10,2,8,24,14,32,27,3,9,
                   19,13,30,6,22,11,4,25};
  int PC1_B[$] = '{57,49,41,33,25,17,9,1,58,50,42,34,26,18,10,2,59,51,43,35,27,19,11,3,
                   60,52,44,36,63,55,47,39,31,23,15,7,62,54,46,38,30,22,14,6,61,53,45,37,
                   29,21,13,5,28,20,12,4};
  int PC2_B[$] = '{14,17,11,24,1,5,3,28,15,6,21,10,23,19,12,4,26,8,16,7,27,20,13,2,
                   41,52,31,37,47,55,30,40,51,45,33,48,44,49,39,56,34,53,46,42,50,36,29,32};
  int LS[$]    = '{1,1,2,2,2,2,2,2,1,2,2,2,2,2,2,1};
  int SB[$] = '{
    14,4,13,1,2,15,11,8,3,10,6,12,5,9,0,7, 0,15,7,4,14,2,13,1,10,6,12,11,9,5,3,8,
    4,1,14,8,13,6,2,11,15,12,9,7,3,10,5,0, 15,12,8,2,4,9,1,7,5,11,3,14,10,0,6,13,
    15,1,8,14,6,11,3,4,9,7,2,13,12,0,5,10, 3,13,4,7,15,2,8,14,12,0,1,10,6,9,11,5,
    0,14,7,11,10,4,13,1,5,8,12,6,9,3,2,15, 13,8,10,1,3,15,4,2,11,6,7,12,0,5,14,9,
    10,0,9,14,6,3,15,5,1,13,12,7,11,4,2,8, 13,7,0,9,3,4,6,10,2,8,5,14,12,11,15,1,
    13,6,4,9,8,15,3,0,11,1,2,12,5,10,14,7, 1,10,13,0,6,9,8,7,4,15,14,3,11,5,2,12,
    7,13,14,3,0,6,9,10,1,2,8,5,11,12,4,15, 13,8,11,5,6,15,0,3,4,7,2,12,1,10,14,9,
    10,6,9,0,12,11,7,13,15,1,3,14,5,2,8,4, 3,15,0,6,10,1,13,8,9,4,5,11,12,7,2,14,
    2,12,4,1,7,10,11,6,8,5,3,15,13,0,14,9, 14,11,2,12,4,7,13,1,5,0,15,10,3,9,8,6,
    4,2,1,11,10,13,7,8,15,9,12,5,6,3,0,14, 11,8,12,7,1,14,2,13,6,15,0,9,10,4,5,3,
    12,1,10,15,9,2,6,8,0,13,3,4,14,7,5,11, 10,15,4,2,7,12,9,5,6,1,13,14,0,11,3,8,
    9,14,15,5,2,8,12,3,7,0,4,10,1,13,11,6, 4,3,2,12,9,5,15,10,11,14,1,7,6,0,8,13,
    4,11,2,14,15,0,8,13,3,12,9,7,5,10,6,1, 13,0,11,7,4,9,1,10,14,3,5,12,2,15,8,6,
    1,4,11,13,12,3,7,14,10,15,6,8,0,5,9,2, 6,11,13,8,1,4,10,7,9,5,0,15,14,2,3,12,
    13,2,8,4,6,15,11,1,10,9,3,14,5,0,12,7, 1,15,13,8,10,3,7,4,12,5,6,11,0,14,9,2,
    7,11,4,1,9,12,14,2,0,6,10,13,15,3,5,8, 2,1,14,7,4,10,8,13,15,12,9,0,3,5,6,11};

  // Selected bits of v (w bits wide, DES bit 1 = MSB), packed right-aligned in table order.
  function automatic logic [63:0] permute(input logic [63:0] v, input int w, input int tab[$]);
    logic [63:0] y = '0;
    foreach (tab[i]) y = {y[62:0], 1'(v >> (w - tab[i]))};
    return y;
  endfunction

  function automatic logic [31:0] fbox(input logic [31:0] r, input logic [47:0] k);
    logic [63:0] e, s, p;
    logic [47:0] x;
    int b, row, col;
    s = '0;
    e = permute({32'h0, r}, 32, E_B);
    x = e[47:0] ^ k;
    for (int j = 0; j < 8; j++) begin
      b   = int'((x >> (42 - 6 * j)) & 48'h3f);
      row = ((b >> 5) & 1) * 2 + (b & 1);
      col = (b >> 1) & 15;
      s   = (s << 4) | 64'(SB[j * 64 + row * 16 + col]);
    end
    p = permute(s, 32, P_B);
    return p[31:0];
  endfunction

  function automatic logic [63:0] des_dec(input logic [63:0] ct, input logic [63:0] k);
    logic [63:0] cd, v, t64;
    logic [27:0] c, d;
    logic [47:0] ks [16];
    logic [31:0] l, r, t;
    cd = permute(k, 64, PC1_B);
    c  = cd[55:28];
    d  = cd[27:0];
    for (int i = 0; i < 16; i++) begin
      repeat (LS[i]) begin
        c = {c[26:0], c[27]};
        d = {d[26:0], d[27]};
      end
      t64   = permute({8'h0, c, d}, 56, PC2_B);
      ks[i] = t64[47:0];
    end
    v = permute(ct, 64, IP_B);
    l = v[63:32];
    r = v[31:0];
    for (int i = 15; i >= 0; i--) begin
      t = r;
      r = l ^ fbox(r, ks[i]);
      l = t;
    end
    return permute({r, l}, 64, FP_B);
  endfunction

  int n_checks = 0;
  int n_fail   = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic timeout_fail(input string name);
    n_checks++;
    n_fail++;
    $display("FAIL %s: timed out at %0t", name, $time);
  endtask

  // Transaction-level model: accept when idle, 16 busy cycles, then hold until taken.
  int          m_left = 0;
  logic        m_outv = 1'b0;
  logic [63:0] m_pt   = '0;
  logic [63:0] m_pend = '0;
  logic [63:0] got_q[$];

  always @(posedge clk) begin
    if (!rst && bus.out_valid && bus.out_ready) got_q.push_back(bus.plaintext);
    if (rst) begin
      m_left <= 0;
      m_outv <= 1'b0;
      m_pt   <= '0;
    end else if (m_left > 0) begin
      m_left <= m_left - 1;
      if (m_left == 1) begin
        m_outv <= 1'b1;
        m_pt   <= m_pend;
      end
    end else if (m_outv) begin
      if (bus.out_ready) m_outv <= 1'b0;
    end else if (bus.in_valid) begin
      m_pend <= des_dec(bus.ciphertext, bus.key);
      m_left <= 16;
    end
  end

  always @(negedge clk) begin
    chk("in_ready",  64'(bus.in_ready),  64'(m_left == 0 && !m_outv));
    chk("busy",      64'(bus.busy),      64'(m_left > 0));
    chk("out_valid", 64'(bus.out_valid), 64'(m_outv));
    chk("plaintext", bus.plaintext, m_pt);
  end

  bit rand_ready = 1'b0;
  always @(negedge clk) if (rand_ready) bus.out_ready = 1'($urandom_range(0, 1));

  localparam logic [63:0] K1  = 64'h133457799BBCDFF1;
  localparam logic [63:0] C1  = 64'h85E813540F0AB405;
  localparam logic [63:0] P1  = 64'h0123456789ABCDEF;
  localparam logic [63:0] K2  = 64'h0E329232EA6D0D73;
  localparam logic [63:0] C2  = 64'h0000000000000000;
  localparam logic [63:0] P2  = 64'h8787878787878787;
  localparam logic [63:0] KW  = 64'h0101010101010101;
  localparam logic [63:0] CW  = 64'h8CA64DE9C1B123A7;
  localparam logic [63:0] PW  = 64'h0000000000000000;

  // Called just after a negedge; returns at the negedge following the accept edge.
  task automatic send(input logic [63:0] ct, input logic [63:0] k, input bit scramble, output time t_acc);
    int guard = 0;
    bus.ciphertext = ct;
    bus.key        = k;
    bus.in_valid   = 1'b1;
    while (!bus.in_ready && guard < 200) begin
      @(negedge clk);
      guard++;
    end
    if (guard >= 200) timeout_fail("accept");
    @(posedge clk);
    t_acc = $time;
    @(negedge clk);
    bus.in_valid = 1'b0;
    if (scramble) begin
      bus.ciphertext = {$urandom, $urandom};
      bus.key        = {$urandom, $urandom};
    end
  endtask

  task automatic wait_out(input bit scramble, output time t_ov);
    int guard = 0;
    while (!bus.out_valid && guard < 60) begin
      if (scramble) begin
        bus.ciphertext = {$urandom, $urandom};
        bus.key        = {$urandom, $urandom};
      end
      @(negedge clk);
      guard++;
    end
    if (guard >= 60) timeout_fail("out_valid");
    t_ov = $time;
  endtask

  initial begin
    time t_a, t_o;
    time t_b2b [3];
    logic [63:0] vc [3];
    logic [63:0] vk [3];
    logic [63:0] vp [3];
    int guard;
    bus.in_valid   = 1'b0;
    bus.ciphertext = '0;
    bus.key        = '0;
    bus.out_ready  = 1'b0;

    @(negedge clk);
    chk("rst_in_ready",  64'(bus.in_ready), 64'd1);
    chk("rst_busy",      64'(bus.busy), 64'd0);
    chk("rst_out_valid", 64'(bus.out_valid), 64'd0);
    chk("rst_plaintext", bus.plaintext, 64'h0);
    @(negedge clk);
    rst = 1'b0;

    chk("model_vec1", des_dec(C1, K1), P1);
    chk("model_vec2", des_dec(C2, K2), P2);
    chk("model_weak", des_dec(CW, KW), PW);

    // Known vector, ports scrambled while rounds run
    bus.out_ready = 1'b1;
    send(C1, K1, 1'b1, t_a);
    wait_out(1'b1, t_o);
    chk("vec1_latency", 64'((t_o - t_a) / 10), 64'd16);
    chk("vec1_pt", bus.plaintext, P1);
    @(negedge clk);
    chk("vec1_valid_one_cycle", 64'(bus.out_valid), 64'd0);

    // Backpressure for 10 cycles
    bus.out_ready = 1'b0;
    send(C2, K2, 1'b0, t_a);
    wait_out(1'b0, t_o);
    for (int i = 0; i < 10; i++) begin
      chk("bp_valid", 64'(bus.out_valid), 64'd1);
      chk("bp_pt", bus.plaintext, P2);
      chk("bp_in_ready", 64'(bus.in_ready), 64'd0);
      @(negedge clk);
    end
    bus.out_ready = 1'b1;
    @(negedge clk);
    chk("bp_released", 64'(bus.out_valid), 64'd0);
    chk("bp_pt_held", bus.plaintext, P2);

    send(CW, KW, 1'b0, t_a);
    wait_out(1'b0, t_o);
    chk("weak_pt", bus.plaintext, PW);

    send(C1, K1 ^ 64'h0101010101010101, 1'b1, t_a);
    wait_out(1'b0, t_o);
    chk("parity_pt", bus.plaintext, P1);

    // Reset during round 7
    @(negedge clk);
    send(C2, K2, 1'b0, t_a);
    repeat (6) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    chk("midrst_in_ready",  64'(bus.in_ready), 64'd1);
    chk("midrst_busy",      64'(bus.busy), 64'd0);
    chk("midrst_out_valid", 64'(bus.out_valid), 64'd0);
    chk("midrst_pt",        bus.plaintext, 64'h0);
    rst = 1'b0;
    send(C1, K1, 1'b0, t_a);
    wait_out(1'b0, t_o);
    chk("after_rst_pt", bus.plaintext, P1);

    // Back-to-back with in_valid held
    @(negedge clk);
    got_q.delete();
    vc = '{C1, C2, CW};
    vk = '{K1, K2, KW};
    vp = '{P1, P2, PW};
    bus.in_valid = 1'b1;
    for (int k = 0; k < 3; k++) begin
      bus.ciphertext = vc[k];
      bus.key        = vk[k];
      guard = 0;
      while (!bus.in_ready && guard < 40) begin
        @(negedge clk);
        guard++;
      end
      if (guard >= 40) timeout_fail("b2b_accept");
      @(posedge clk);
      t_b2b[k] = $time;
      @(negedge clk);
    end
    bus.in_valid = 1'b0;
    guard = 0;
    while (got_q.size() < 3 && guard < 60) begin
      @(negedge clk);
      guard++;
    end
    if (guard >= 60) timeout_fail("b2b_drain");
    chk("b2b_spacing01", 64'((t_b2b[1] - t_b2b[0]) / 10), 64'd18);
    chk("b2b_spacing12", 64'((t_b2b[2] - t_b2b[1]) / 10), 64'd18);
    chk("b2b_count", 64'(got_q.size()), 64'd3);
    for (int k = 0; k < 3 && k < got_q.size(); k++) chk("b2b_pt", got_q[k], vp[k]);

    // Random blocks with random consumer backpressure
    @(negedge clk);
    got_q.delete();
    rand_ready = 1'b1;
    for (int n = 0; n < 30; n++) begin
      repeat ($urandom_range(0, 3)) @(negedge clk);
      send({$urandom, $urandom}, {$urandom, $urandom}, 1'($urandom_range(0, 1)), t_a);
    end
    guard = 0;
    while (!bus.in_ready && guard < 300) begin
      @(negedge clk);
      guard++;
    end
    if (guard >= 300) timeout_fail("rand_drain");
    chk("rand_count", 64'(got_q.size()), 64'd30);
    rand_ready    = 1'b0;
    bus.out_ready = 1'b1;
    repeat (2) @(negedge clk);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #500000;
    timeout_fail("watchdog");
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule

// File: doc/des_decrypt_core.md
Name: des_decrypt_core

Overview:
- Iterative DES decryption engine: one 64-bit ciphertext block in, one 64-bit plaintext block out, using the same 16-round Feistel datapath as the team's encryption core.
- Subkeys are applied in reverse order, K16 down to K1.
- Ready/valid handshakes on both sides; sits between the link/receive buffer and the plaintext consumer.
- Processes one block at a time, 16 clock cycles of round processing per block.

Parameters:
- None. DES geometry is fixed: 64-bit block, 56-bit effective key, 16 rounds.

Ports:
- clk  in  1  rising-edge clock
- rst  in  1  synchronous, active-high reset
- in_valid  in  1  ciphertext/key pair presented
- in_ready  out  1  core can accept a block (IDLE state)
- ciphertext  in  64  bit 63 = DES bit 1 (MSB-first numbering)
- key  in  64  bit 63 = DES bit 1; parity bits (DES bits 8,16,…,64) ignored
- out_valid  out  1  plaintext valid; held until accepted
- out_ready  in  1  consumer accepts plaintext
- plaintext  out  64  decrypted block, same bit order
- busy  out  1  high while rounds are in progress

Behaviour:
- Clock and reset: single clock domain, clk. rst is synchronous and active-high, sampled on the rising edge of clk.
- Reset values: state=IDLE, round counter=0, L/R/key registers=0, plaintext=64'h0, out_valid=0, busy=0, in_ready=1.
- Reset mid-operation: rst at any edge aborts the block in flight and discards it. Next cycle shows the reset values; no out_valid for the aborted block.
- States:
  - IDLE: in_ready=1. On an edge with in_valid=1, latch IP(ciphertext) into L/R and PC-1(key) into C/D; go to ROUND, cnt=0.
  - ROUND: busy=1, in_ready=0. Each edge performs one Feistel round with subkey K(16-cnt): L<=R, R<=L xor f(R,K). cnt increments; after cnt=15, go to DONE and register plaintext=FP(R16||L16).
  - DONE: out_valid=1, in_ready=0, plaintext stable. On an edge with out_ready=1, go to IDLE and drop out_valid.
- Latency: accept edge T; out_valid rises after edge T+16 (16 round edges). Sustained throughput is one block per 18 cycles when out_ready is tied high.
- Reverse key schedule:
  - Either precompute all 16 subkeys combinationally from the latched key, or run C/D right-rotations from PC-1 state.
  - Right-rotation schedule: 0 before K16, then 1,2,2,2,2,2,2,1,2,2,2,2,2,2,1 for K15..K1.
  - Either way, the latched key must not change during ROUND; the key port is don't-care after acceptance.
- ciphertext and key are sampled only on the accept edge. Changes while busy have no effect.
- in_valid during ROUND/DONE is ignored (in_ready=0); the source must hold it.
- out_ready asserted while not in DONE has no effect.
- DONE with out_ready=1 and in_valid=1 on the same edge: the result is consumed and the state goes to IDLE; the new block is accepted on the following edge (no same-cycle turnaround).
- plaintext holds its last value after the handshake until the next block completes. It is zeroed only by rst.
- The implementation may reuse the team's existing IP/FP/E/P/S-box/PC-1/PC-2 modules. Any reset input on those modules is tied to its inactive level.

Test Plan:
- Known vector: key=133457799BBCDFF1, ciphertext=85E813540F0AB405, out_ready=1 → plaintext=0123456789ABCDEF, out_valid exactly 16 cycles after the accept edge, held for 1 cycle.
- Second vector with backpressure: key=0E329232EA6D0D73, ciphertext=0000000000000000, out_ready=0 for 10 cycles → plaintext=8787878787878787; out_valid and plaintext stable all 10 cycles, in_ready=0 throughout.
- Weak key: key=0101010101010101, ciphertext=8CA64DE9C1B123A7 → plaintext=0000000000000000.
- Parity/stability:
  - Key FE…-style parity flips (e.g. 123456789ABCDEF1 vs 133457799BBCDFF1 differing only in parity bits) give identical plaintext.
  - Toggling the ciphertext/key ports during ROUND does not change the result.
- Reset mid-operation: assert rst at round 7 of a block → next cycle in_ready=1, busy=0, out_valid=0, plaintext=0. A subsequent block decrypts correctly.
- Back-to-back: in_valid held high with 3 vectors and out_ready=1 → three correct results, accepts spaced 18 cycles apart, no dropped or duplicated blocks.
